// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide execute unit.
// Holds the funct3 op encodings, the unit's FSM state encoding and the
// default datapath width shared with the ALU and register file.
package muldiv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  // funct3 encodings of the M-extension ops
  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  // IDLE must stay at zero: reset forces the all-zero encoding
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    FAST = 3'd4
  } state_e;

  // Bit 2 of funct3 separates the divide group from the multiply group
  function automatic logic md_is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Iterative unsigned restoring divider core.
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_start                   load new operands and begin dividing
//   i_dividend, i_divisor     unsigned operands (magnitudes)
//   o_quotient, o_remainder   results, final once the last iteration is done
//   o_done                    high in the cycle whose closing edge runs the last iteration
// One quotient bit is produced per cycle; XLEN iterations follow the start edge.
module muldiv_divider #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder,
  output logic            o_done
);

  localparam int unsigned CntW = $clog2(XLEN + 1);

  logic [XLEN-1:0] r_quot;     // dividend shifts out the top, quotient bits shift in below
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_divisor;
  logic [CntW-1:0] r_cnt;

  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic            w_fits;

  always_comb begin
    w_shift = {r_rem, r_quot[XLEN-1]};
    w_diff  = w_shift - {1'b0, r_divisor};
    // Partial remainder is always < 2*divisor, so bit XLEN of the difference is a clean borrow
    w_fits  = ~w_diff[XLEN];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_quot    <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_cnt     <= '0;
    end else if (i_start) begin
      r_quot    <= i_dividend;
      r_rem     <= '0;
      r_divisor <= i_divisor;
      r_cnt     <= CntW'(XLEN);
    end else if (r_cnt != '0) begin
      r_quot <= {r_quot[XLEN-2:0], w_fits};
      r_rem  <= w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
      r_cnt  <= r_cnt - CntW'(1);
    end
  end

  assign o_quotient  = r_quot;
  assign o_remainder = r_rem;
  assign o_done      = (r_cnt == CntW'(1));

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M execute unit sitting beside the EX-stage ALU.
// Ports:
//   i_clk, i_rst_n             clock, async active-low reset
//   i_start                    request strobe, taken only while not busy and not flushing
//   i_op                       funct3 of the M-extension op
//   i_operand_a, i_operand_b   rs1 / rs2 values, sampled only on accept
//   i_tag_in                   destination register of the request
//   i_flush                    kill any in-flight op and drop a same-cycle start
//   o_busy                     unit occupied
//   o_result_valid             one-cycle result pulse
//   o_result, o_tag_out        result and its rd tag, held until the next pulse
// Multiplies run through a MUL_LATENCY-deep pipe; divides use the iterative core
// followed by a sign-fix cycle; divide-by-zero and signed overflow finish in one cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN        = XLEN_DEFAULT,
  parameter int unsigned MUL_LATENCY = 2,
  parameter int unsigned TAG_W       = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [XLEN-1:0]  i_operand_a,
  input  logic [XLEN-1:0]  i_operand_b,
  input  logic [TAG_W-1:0] i_tag_in,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_result_valid,
  output logic [XLEN-1:0]  o_result,
  output logic [TAG_W-1:0] o_tag_out
);

  localparam logic [XLEN-1:0] MostNeg    = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [1:0]      MulCntInit = 2'(MUL_LATENCY - 1);

  state_e r_state, w_state_d;

  // Request decode
  logic w_accept, w_is_div, w_signed_div, w_is_rem;
  logic w_a_neg, w_b_neg, w_b_zero, w_ovf, w_fast;
  logic w_sign_a, w_sign_b;
  logic [XLEN-1:0] w_a_mag, w_b_mag, w_fast_res;

  // Multiply path
  logic signed [XLEN:0] w_mul_a, w_mul_b;
  logic [2*XLEN-1:0]    w_prod;
  logic [XLEN-1:0]      w_mul_res;
  logic [XLEN-1:0]      r_mul_pipe [MUL_LATENCY];
  logic [1:0]           r_mul_cnt;

  // Divide path
  logic            w_div_start, w_div_done;
  logic [XLEN-1:0] w_quot, w_rem, w_fix_res;

  // State captured on accept
  logic [TAG_W-1:0] r_tag;
  logic             r_is_rem, r_neg_q, r_neg_r;
  logic [XLEN-1:0]  r_fast_res;

  // Output registers
  logic             r_valid, w_valid_d;
  logic [XLEN-1:0]  r_result, w_result_d;
  logic [TAG_W-1:0] r_tag_out, w_tag_d;

  always_comb begin
    w_accept     = i_start && (r_state == IDLE) && !i_flush;
    w_is_div     = md_is_div(i_op);
    w_signed_div = w_is_div && !i_op[0];
    w_is_rem     = i_op[1];
    w_a_neg      = w_signed_div && i_operand_a[XLEN-1];
    w_b_neg      = w_signed_div && i_operand_b[XLEN-1];
    w_a_mag      = w_a_neg ? -i_operand_a : i_operand_a;
    w_b_mag      = w_b_neg ? -i_operand_b : i_operand_b;
    w_b_zero     = (i_operand_b == '0);
    w_ovf        = w_signed_div && (i_operand_a == MostNeg) && (i_operand_b == '1);
    w_fast       = w_is_div && (w_b_zero || w_ovf);
    if (w_b_zero) begin
      w_fast_res = w_is_rem ? i_operand_a : '1;
    end else begin
      w_fast_res = w_is_rem ? '0 : i_operand_a;
    end
    w_div_start = w_accept && w_is_div && !w_fast;
  end

  // One extra sign bit per operand lets a single signed multiplier cover all four variants
  always_comb begin
    w_sign_a  = (i_op[1:0] == MD_MULH[1:0]) || (i_op[1:0] == MD_MULHSU[1:0]);
    w_sign_b  = (i_op[1:0] == MD_MULH[1:0]);
    w_mul_a   = $signed({w_sign_a && i_operand_a[XLEN-1], i_operand_a});
    w_mul_b   = $signed({w_sign_b && i_operand_b[XLEN-1], i_operand_b});
    w_prod    = w_mul_a * w_mul_b;
    w_mul_res = (i_op[1:0] == MD_MUL[1:0]) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(MUL_LATENCY); i++) begin
        r_mul_pipe[i] <= '0;
      end
      r_mul_cnt <= '0;
    end else begin
      if (w_accept && !w_is_div) begin
        r_mul_pipe[0] <= w_mul_res;
        r_mul_cnt     <= MulCntInit;
      end
      if (r_state == MUL) begin
        for (int i = 1; i < int'(MUL_LATENCY); i++) begin
          r_mul_pipe[i] <= r_mul_pipe[i-1];
        end
        if (r_mul_cnt != 2'd0) begin
          r_mul_cnt <= r_mul_cnt - 2'd1;
        end
      end
    end
  end

  muldiv_divider #(
    .XLEN (XLEN)
  ) u_divider (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (w_div_start),
    .i_dividend  (w_a_mag),
    .i_divisor   (w_b_mag),
    .o_quotient  (w_quot),
    .o_remainder (w_rem),
    .o_done      (w_div_done)
  );

  // Quotient is negative iff operand signs differ; remainder follows the dividend
  always_comb begin
    if (r_is_rem) begin
      w_fix_res = r_neg_r ? -w_rem : w_rem;
    end else begin
      w_fix_res = r_neg_q ? -w_quot : w_quot;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tag      <= '0;
      r_is_rem   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_fast_res <= '0;
    end else if (w_accept) begin
      r_tag      <= i_tag_in;
      r_is_rem   <= w_is_rem;
      r_neg_q    <= w_a_neg ^ w_b_neg;
      r_neg_r    <= w_a_neg;
      r_fast_res <= w_fast_res;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_valid_d  = 1'b0;
    w_result_d = r_result;
    w_tag_d    = r_tag_out;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (!w_is_div) begin
            w_state_d = MUL;
          end else if (w_fast) begin
            w_state_d = FAST;
          end else begin
            w_state_d = DIV;
          end
        end
      end
      MUL: begin
        if (r_mul_cnt == 2'd0) begin
          w_state_d  = IDLE;
          w_valid_d  = 1'b1;
          w_result_d = r_mul_pipe[MUL_LATENCY-1];
          w_tag_d    = r_tag;
        end
      end
      DIV: begin
        if (w_div_done) begin
          w_state_d = FIX;
        end
      end
      FIX: begin
        w_state_d  = IDLE;
        w_valid_d  = 1'b1;
        w_result_d = w_fix_res;
        w_tag_d    = r_tag;
      end
      FAST: begin
        w_state_d  = IDLE;
        w_valid_d  = 1'b1;
        w_result_d = r_fast_res;
        w_tag_d    = r_tag;
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase
    // Flush kills whatever would complete on this edge; held outputs stay put
    if (i_flush) begin
      w_state_d  = IDLE;
      w_valid_d  = 1'b0;
      w_result_d = r_result;
      w_tag_d    = r_tag_out;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_valid   <= 1'b0;
      r_result  <= '0;
      r_tag_out <= '0;
    end else begin
      r_state   <= w_state_d;
      r_valid   <= w_valid_d;
      r_result  <= w_result_d;
      r_tag_out <= w_tag_d;
    end
  end

  assign o_busy         = (r_state != IDLE);
  assign o_result_valid = r_valid;
  assign o_result       = r_result;
  assign o_tag_out      = r_tag_out;

endmodule
